// File: rtl/mul8_seq_pkg.sv
// Shared definitions for the mul8 Wishbone sequencer: register offsets, CTRL bit positions,
// FSM states and the settle-counter width.
package mul8_seq_pkg;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_OPND = 4'h4;
    localparam logic [3:0] OFF_RES  = 4'h8;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_IE    = 3;

    // Wide enough for the largest legal MUL_LAT of 15.
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    // Read image of CTRL/STAT bits [3:0].
    typedef struct packed {
        logic ie;
        logic ovr;
        logic done;
        logic busy;
    } stat_t;

endpackage

// File: rtl/mul8_wb_sequencer_if.sv
// Wishbone slave bus bundle for the mul8 sequencer; the SoC side uses master, the block uses slave.
interface mul8_wb_sequencer_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/mul8_seq_wbif.sv
// Wishbone front end: address decode, single-cycle ack, registered read mux and
// per-register strobes that are valid in the cycle a request is sampled.
module mul8_seq_wbif
    import mul8_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          P_W       = 20
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    mul8_wb_sequencer_if.slave wb,
    input  stat_t              stat_i,
    input  logic [7:0]         a_i,
    input  logic [7:0]         b_i,
    input  logic [P_W-1:0]     result_i,
    output logic               ctrl_we_o,
    output logic               opnd_we_o,
    output logic               res_rd_o,
    output logic [15:0]        wdat_o,
    output logic [1:0]         wsel_o
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        req;
    logic        hit;
    logic [3:0]  off;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign unused_bits = ^{wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2]};

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
        hit     = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        off     = wb.wbs_adr_i[3:0];
        rd_word = '0;
        if (hit) begin
            case (off)
                OFF_CTRL: rd_word = {28'h0, stat_i};
                OFF_OPND: rd_word = {16'h0, a_i, b_i};
                OFF_RES:  rd_word = {{(32-P_W){1'b0}}, result_i};
                default:  rd_word = '0;
            endcase
        end
        ack_d     = req;
        dat_d     = (req && !wb.wbs_we_i) ? rd_word : '0;
        ctrl_we_o = req &  wb.wbs_we_i & hit & (off == OFF_CTRL);
        opnd_we_o = req &  wb.wbs_we_i & hit & (off == OFF_OPND);
        res_rd_o  = req & ~wb.wbs_we_i & hit & (off == OFF_RES);
        wdat_o    = wb.wbs_dat_i[15:0];
        wsel_o    = wb.wbs_sel_i[1:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

endmodule

// File: rtl/mul8_wb_sequencer.sv
// Sequencer for the 8x8 multiplier: holds operands, launches, waits MUL_LAT cycles, captures the product.
// Optional level interrupt on DONE is built when MUL8_SEQ_IRQ_EN is defined.
module mul8_wb_sequencer
    import mul8_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MUL_LAT   = 2,
    parameter int          P_W       = 20
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    mul8_wb_sequencer_if.slave wb,
    output logic [7:0]         mul_a_o,
    output logic [7:0]         mul_b_o,
    input  logic [P_W-1:0]     mul_p_i,
    output logic               busy_o
`ifdef MUL8_SEQ_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic [P_W-1:0]     result_q, result_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               busy_q, busy_d;
    logic               ie_q;
`ifdef MUL8_SEQ_IRQ_EN
    logic               ie_d;
`endif

    logic               ctrl_we;
    logic               opnd_we;
    logic               res_rd;
    logic [15:0]        wdat;
    logic [1:0]         wsel;
    logic               start_req;
    stat_t              stat;

    mul8_seq_wbif #(
        .BASE_ADDR (BASE_ADDR),
        .P_W       (P_W)
    ) u_wbif (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wb        (wb),
        .stat_i    (stat),
        .a_i       (a_q),
        .b_i       (b_q),
        .result_i  (result_q),
        .ctrl_we_o (ctrl_we),
        .opnd_we_o (opnd_we),
        .res_rd_o  (res_rd),
        .wdat_o    (wdat),
        .wsel_o    (wsel)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        busy_d    = busy_q;
`ifdef MUL8_SEQ_IRQ_EN
        ie_d      = ie_q;
        if (ctrl_we) ie_d = wdat[CTRL_IE];
`endif
        start_req = ctrl_we & wdat[CTRL_START];

        // Clears come first so a capture on the same edge sets DONE/OVR last and wins.
        if (res_rd) done_d = 1'b0;
        if (ctrl_we && wdat[CTRL_OVR]) ovr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (opnd_we) begin
                    if (wsel[0]) b_d = wdat[7:0];
                    if (wsel[1]) a_d = wdat[15:8];
                end
            end
            SETTLE: begin
                if (start_req || opnd_we) ovr_d = 1'b1;
                if (cnt_q == '0) begin
                    result_d = mul_p_i;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef MUL8_SEQ_IRQ_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) ie_q <= 1'b0;
        else          ie_q <= ie_d;
    end

    assign irq_o = done_q & ie_q;
`else
    assign ie_q = 1'b0;
`endif

    assign stat    = '{ie: ie_q, ovr: ovr_q, done: done_q, busy: busy_q};
    assign mul_a_o = a_q;
    assign mul_b_o = b_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_mul8_wb_sequencer.sv
// Scoreboard bench for mul8_wb_sequencer: directed scenarios plus random bus traffic checked
// against a transaction-level model of the register file and multiply timing.
module tb_mul8_wb_sequencer;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          MUL_LAT = 2;
    localparam int          P_W     = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     mul_a;
    logic [7:0]     mul_b;
    logic [P_W-1:0] mul_p;
    logic           busy;
`ifdef MUL8_SEQ_IRQ_EN
    logic           irq;
`endif

    always #5 clk = ~clk;

    mul8_wb_sequencer_if bus ();

    mul8_wb_sequencer #(
        .BASE_ADDR (BASE),
        .MUL_LAT   (MUL_LAT),
        .P_W       (P_W)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .mul_a_o  (mul_a),
        .mul_b_o  (mul_b),
        .mul_p_i  (mul_p),
        .busy_o   (busy)
`ifdef MUL8_SEQ_IRQ_EN
        ,
        .irq_o    (irq)
`endif
    );

    // Stand-in for the combinational multiplier instance.
    assign mul_p = P_W'(16'(mul_a) * 16'(mul_b));

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference model state: registers plus the edge on which the in-flight multiply lands.
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic [19:0] m_res = '0;
    bit          m_done = 0;
    bit          m_ovr = 0;
    bit          m_ie = 0;
    bit          m_infl = 0;
    int          m_cap = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_a = '0; m_b = '0; m_res = '0;
        m_done = 0; m_ovr = 0; m_ie = 0; m_infl = 0; m_cap = 0;
    endfunction

    // Brings the model up to the state visible just before edge k.
    function automatic void model_sync(int k);
        if (m_infl && m_cap < k) begin
            m_res  = {12'h0, m_a} * {12'h0, m_b};
            m_done = 1;
            m_infl = 0;
        end
    endfunction

    // Applies a bus access sampled on edge k; returns the read data it should produce.
    function automatic logic [31:0] model_access(int k, bit we, logic [31:0] adr,
                                                 logic [31:0] dat, logic [3:0] sel);
        logic [31:0] rd;
        rd = '0;
        model_sync(k);
        if (adr[31:4] == BASE[31:4]) begin
            case (adr[3:0])
                4'h0: begin
                    if (we) begin
                        if (dat[2]) m_ovr = 0;
`ifdef MUL8_SEQ_IRQ_EN
                        m_ie = dat[3];
`endif
                        if (dat[0]) begin
                            if (m_infl) m_ovr = 1;
                            else begin
                                m_infl = 1;
                                m_cap  = k + MUL_LAT;
                                m_done = 0;
                            end
                        end
                    end else begin
                        rd = {28'h0, m_ie, m_ovr, m_done, m_infl};
                    end
                end
                4'h4: begin
                    if (we) begin
                        if (m_infl) m_ovr = 1;
                        else begin
                            if (sel[0]) m_b = dat[7:0];
                            if (sel[1]) m_a = dat[15:8];
                        end
                    end else begin
                        rd = {16'h0, m_a, m_b};
                    end
                end
                4'h8: begin
                    if (!we) begin
                        rd     = {12'h0, m_res};
                        m_done = 0;
                    end
                end
                default: ;
            endcase
        end
        return rd;
    endfunction

    task automatic access(input string name, input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] e;
        int t;
        e = model_access(edge_n + 1, we, adr, dat, sel);
        exp_q.push_back({~we, e});
        name_q.push_back(name);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        t = 0;
        @(negedge clk);
        while (!bus.wbs_ack_o && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!bus.wbs_ack_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no ack within 10 cycles", name);
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: samples just after each rising edge, pops the scoreboard on every ack.
    always @(posedge clk) begin
        logic [32:0] e;
        string nm;
        edge_n++;
        #1;
        model_sync(edge_n + 1);
        if (bus.wbs_ack_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: ack with empty scoreboard at t=%0t", $time);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e[32]) check(nm, bus.wbs_dat_o, e[31:0]);
            end
        end
        check("busy_o", {31'h0, busy}, {31'h0, m_infl});
        check("mul_a_o", {24'h0, mul_a}, {24'h0, m_a});
        check("mul_b_o", {24'h0, mul_b}, {24'h0, m_b});
`ifdef MUL8_SEQ_IRQ_EN
        check("irq_o", {31'h0, irq}, {31'h0, m_done & m_ie});
`endif
    end

    initial begin
        logic [31:0] adr_tab [6];
        logic [31:0] adr, dat;
        bit          we;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        model_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        access("rst_stat", 0, BASE + 32'h0, 0, 4'hF);
        access("rst_res",  0, BASE + 32'h8, 0, 4'hF);

        // 12 * 10 with status polling across the settle window.
        access("opnd_wr1", 1, BASE + 32'h4, 32'h0000_0C0A, 4'b0011);
        access("start1",   1, BASE + 32'h0, 32'h1, 4'hF);
        access("stat1a",   0, BASE + 32'h0, 0, 4'hF);
        access("stat1b",   0, BASE + 32'h0, 0, 4'hF);
        access("res1",     0, BASE + 32'h8, 0, 4'hF);
        access("stat1c",   0, BASE + 32'h0, 0, 4'hF);

        // Full-scale operands.
        access("opnd_wr2", 1, BASE + 32'h4, 32'h0000_FFFF, 4'b0011);
        access("start2",   1, BASE + 32'h0, 32'h1, 4'hF);
        idle(3);
        access("stat2a",   0, BASE + 32'h0, 0, 4'hF);
        access("res2",     0, BASE + 32'h8, 0, 4'hF);
        access("stat2b",   0, BASE + 32'h0, 0, 4'hF);

        // Overrun: START while busy, then OPERAND write while busy.
        access("start3",   1, BASE + 32'h0, 32'h1, 4'hF);
        access("start3_busy", 1, BASE + 32'h0, 32'h1, 4'hF);
        access("stat3a",   0, BASE + 32'h0, 0, 4'hF);
        access("start3b",  1, BASE + 32'h0, 32'h1, 4'hF);
        access("opnd3_busy", 1, BASE + 32'h4, 32'h0000_1234, 4'b0011);
        access("stat3b",   0, BASE + 32'h0, 0, 4'hF);
        access("opnd3_rd", 0, BASE + 32'h4, 0, 4'hF);
        access("res3",     0, BASE + 32'h8, 0, 4'hF);
        access("ovr_clr",  1, BASE + 32'h0, 32'h4, 4'hF);
        access("stat3c",   0, BASE + 32'h0, 0, 4'hF);

        // Launch and overrun-clear in one write.
        access("start_ovrclr", 1, BASE + 32'h0, 32'h5, 4'hF);
        idle(3);
        access("stat3d",   0, BASE + 32'h0, 0, 4'hF);

        // Byte-select on OPERAND, unmapped offsets, result write ignored.
        access("opnd4_wr", 1, BASE + 32'h4, 32'h0000_AB55, 4'b0010);
        access("opnd4_rd", 0, BASE + 32'h4, 0, 4'hF);
        access("off_c_rd", 0, BASE + 32'hC, 0, 4'hF);
        access("res_wr",   1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        access("res4_rd",  0, BASE + 32'h8, 0, 4'hF);
        access("oow_rd",   0, 32'h2000_0004, 0, 4'hF);
        access("oow_wr",   1, 32'h3000_0014, 32'h1, 4'hF);
        access("stat4",    0, BASE + 32'h0, 0, 4'hF);

        // Reset during SETTLE aborts the multiply.
        access("start5",   1, BASE + 32'h0, 32'h1, 4'hF);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("rst5_busy", {31'h0, busy}, 32'h0);
        check("rst5_a", {24'h0, mul_a}, 32'h0);
        check("rst5_b", {24'h0, mul_b}, 32'h0);
        idle(5);
        access("rst5_stat", 0, BASE + 32'h0, 0, 4'hF);
        access("rst5_res",  0, BASE + 32'h8, 0, 4'hF);

`ifdef MUL8_SEQ_IRQ_EN
        access("ie_set",   1, BASE + 32'h0, 32'h8, 4'hF);
        access("opnd6_wr", 1, BASE + 32'h4, 32'h0000_0305, 4'b0011);
        access("start6",   1, BASE + 32'h0, 32'h9, 4'hF);
        idle(4);
        access("stat6",    0, BASE + 32'h0, 0, 4'hF);
        access("res6",     0, BASE + 32'h8, 0, 4'hF);
        idle(2);
        access("start6b",  1, BASE + 32'h0, 32'h9, 4'hF);
        idle(4);
        access("ie_clr",   1, BASE + 32'h0, 32'h0, 4'hF);
        idle(2);
`endif

        // Random traffic over every decode region.
        adr_tab = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC,
                    BASE + 32'h10, 32'h2000_0008};
        for (int i = 0; i < 80; i++) begin
            adr = adr_tab[$urandom_range(0, 5)];
            we  = ($urandom % 2) == 1;
            dat = $urandom;
            if (adr == BASE && we && ($urandom % 2) == 1) dat[0] = 1'b1;
            access("rand", we, adr, dat, 4'($urandom));
            idle($urandom_range(0, 3));
        end
        idle(MUL_LAT + 2);
        access("final_stat", 0, BASE + 32'h0, 0, 4'hF);
        access("final_res",  0, BASE + 32'h8, 0, 4'hF);
        idle(2);
        check("scoreboard_drain", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
